neuron_mac_seq: RTL and testbench
=================================

Name: neuron_mac_seq

Overview:
- Downstream consumer of the weights ROM. For one neuron, walks ROM addresses, reads one signed Q-format weight per cycle, multiplies it by the matching activation, and accumulates the products.
- After NUM_IN terms it rescales the sum to N-bit Q format, saturates it, optionally applies ReLU, and presents the result on a valid/ready output.
- A layer controller launches it with start and sets w_base per neuron.

Parameters:
- N, 8, weight/activation/output width (signed two's complement).
- Q, 7, fractional bits of weights, activations and output.
- NUM_IN, 16, number of products per neuron (1..256).
- ACC_W, 2*N+8, accumulator width; must be at least 2*N+ceil(log2(NUM_IN)).
- RELU, 0, 1 = clamp negative results to 0.

Ports:
- clk, in, 1, system clock; all state changes on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, single-cycle launch request.
- w_base, in, 8, first weight address; sampled when start is accepted.
- rom_addr, out, 8, weight ROM address.
- rom_data, in, N, signed weight. Valid at the first rising edge after rom_addr changes (ROM registers on falling edge).
- act_addr, out, 8, activation buffer index (0..NUM_IN-1).
- act_data, in, N, signed activation. Same one-cycle latency as rom_data.
- busy, out, 1, high from start acceptance until the output is accepted.
- out_data, out, N, signed saturated result.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, downstream accepts when out_valid&&out_ready.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - rom_addr=0, act_addr=0, counter=0, acc=0.
  - out_data=0, out_valid=0, busy=0.
  - Applies immediately and mid-operation; any partial sum is discarded and no output is produced.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - start=1 at edge t0 -> RUN.
  - At t0: acc<=0, rom_addr<=w_base, act_addr<=0, counter<=0, busy<=1.
- RUN, edges t0+1 .. t0+NUM_IN-1:
  - acc <= acc + sext(rom_data*act_data), using data for the address issued one cycle earlier.
  - rom_addr <= rom_addr+1 (8-bit, wraps 0xFF->0x00).
  - act_addr <= act_addr+1; counter <= counter+1.
  - When counter==NUM_IN-1 -> DRAIN; addresses hold.
- DRAIN, edge t0+NUM_IN:
  - Final product accumulated. -> OUT.
  - For NUM_IN=1, RUN lasts zero edges: go directly from the start edge to DRAIN.
- OUT, edge t0+NUM_IN+1:
  - out_data <= result; out_valid <= 1.
  - Start-to-valid latency is exactly NUM_IN+1 cycles.
- OUT hold:
  - out_valid and out_data stay stable until an edge with out_ready=1.
  - At that edge: out_valid<=0, busy<=0 -> IDLE.
  - Earliest next start is accepted the cycle after the handshake (start is not accepted in the same edge).
- Start while busy=1 is ignored, with no queuing. w_base changes while busy are ignored.
- Arithmetic:
  - Product is a 2N-bit signed Q(2Q) value, sign-extended to ACC_W.
  - The accumulator does not overflow by construction of ACC_W.
  - Result = acc >>> Q (arithmetic shift, floor toward -inf).
  - Saturate to [-2^(N-1), 2^(N-1)-1].
  - If RELU=1 and the saturated value is negative, the result is 0.
- Address wrap: w_base+NUM_IN > 256 wraps modulo 256; no error flag.
- rom_addr and act_addr are registered outputs driven only on rising edges, which guarantees half a cycle of setup to the ROM's falling-edge read.

Test Plan:
Unless stated, tests use NUM_IN=4, RELU=0, N=8, Q=7 and a ROM/activation model with 1-cycle latency.
- Reset: rst_n low mid-run -> all outputs go to 0 asynchronously; after release and a fresh start, the result is correct and no stale out_valid appears.
- Positive, exact: weights 0x20 and acts 0x40 (all four) -> acc=8192 -> out_data=0x40; out_valid rises exactly 5 cycles after the start edge.
- Saturation: weights 0x40 and acts 0x40 -> acc=16384 -> out_data=0x7F. Weights 0xC0 and acts 0x40 -> out_data=0x80. Same negative case with RELU=1 -> 0x00.
- Flooring: a single nonzero term, weight 0xFF (-1/128) times act 0x01 -> acc=-1 -> out_data=0xFF; weight 0x01 times act 0x01 -> 0x00.
- Wrap: w_base=0xFE -> rom_addr sequence 0xFE,0xFF,0x00,0x01 on consecutive cycles; act_addr sequence 0,1,2,3.
- Backpressure/ignored start: out_ready held low 6 cycles with start pulsed during RUN and OUT -> out_data stable and exactly one result. After the handshake, busy falls, and a start on the next cycle launches a new run.

Source files
------------

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: computes one neuron's weighted sum by walking the weight
// ROM and the activation buffer, one signed product per cycle. The sum is
// rescaled to N-bit Q format, saturated, optionally passed through ReLU, and
// presented on a valid/ready output.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, w_base       launch request and first weight address (sampled on accept)
//   rom_addr, rom_data  weight ROM address and signed weight (1-cycle latency)
//   act_addr, act_data  activation index and signed activation (1-cycle latency)
//   busy                high from accepted start until the result is taken
//   out_data, out_valid saturated result and its valid flag
//   out_ready           downstream accept
module neuron_mac_seq #(
  parameter int N      = 8,
  parameter int Q      = 7,
  parameter int NUM_IN = 16,
  parameter int ACC_W  = 2*N+8,
  parameter int RELU   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   w_base,
  output logic [7:0]   rom_addr,
  input  logic [N-1:0] rom_data,
  output logic [7:0]   act_addr,
  input  logic [N-1:0] act_data,
  output logic         busy,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

  localparam logic [7:0] LAST_CNT = 8'(NUM_IN - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};
  localparam logic [N-1:0] OUT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] OUT_MIN = {1'b1, {(N-1){1'b0}}};

  state_e                   state_q, state_d;
  logic [7:0]               rom_addr_q, rom_addr_d;
  logic [7:0]               act_addr_q, act_addr_d;
  logic [7:0]               cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     busy_q, busy_d;
  logic                     out_valid_q, out_valid_d;
  logic [N-1:0]             out_data_q, out_data_d;

  logic signed [2*N-1:0]    w_ext, a_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, shifted;
  logic [N-1:0]             result;

  // Datapath: signed product, rescale, saturate, optional ReLU.
  always_comb begin
    w_ext    = {{N{rom_data[N-1]}}, rom_data};
    a_ext    = {{N{act_data[N-1]}}, act_data};
    prod     = w_ext * a_ext;
    prod_ext = {{(ACC_W-2*N){prod[2*N-1]}}, prod};
    shifted  = acc_q >>> Q;
    if (shifted > SAT_MAX) begin
      result = OUT_MAX;
    end else if (shifted < SAT_MIN) begin
      result = OUT_MIN;
    end else begin
      result = shifted[N-1:0];
    end
    if (RELU != 0 && result[N-1]) begin
      result = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    act_addr_d  = act_addr_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d      = '0;
          rom_addr_d = w_base;
          act_addr_d = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = (NUM_IN == 1) ? DRAIN : RUN;
        end
      end
      RUN: begin
        // Data arriving now belongs to the address issued last cycle; the
        // last address is issued on the edge that moves us to DRAIN.
        acc_d      = acc_q + prod_ext;
        rom_addr_d = rom_addr_q + 8'd1;
        act_addr_d = act_addr_q + 8'd1;
        cnt_d      = cnt_q + 8'd1;
        if (cnt_d == LAST_CNT) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        acc_d   = acc_q + prod_ext;
        state_d = OUT;
      end
      OUT: begin
        // First cycle in OUT registers the result; afterwards hold until taken.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = result;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      act_addr_q  <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      act_addr_q  <= act_addr_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign act_addr  = act_addr_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: NUM_IN=4 instances with RELU=0 and
// RELU=1 run in lockstep from a shared table, plus a NUM_IN=1 instance.
module tb_neuron_mac_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, out_ready;
  logic [7:0] w_base;
  logic [7:0] rom_addr, act_addr, rom_data, act_data, out_data;
  logic       busy, out_valid;
  logic [7:0] rom_addr_r, act_addr_r, rom_data_r, act_data_r, out_data_r;
  logic       busy_r, out_valid_r;
  logic       start1, out_ready1;
  logic [7:0] w_base1;
  logic [7:0] rom_addr1, act_addr1, rom_data1, act_data1, out_data1;
  logic       busy1, out_valid1;

  logic [7:0] wmem [256];
  logic [7:0] amem [4];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  neuron_mac_seq #(.N(8), .Q(7), .NUM_IN(4), .ACC_W(24), .RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .w_base(w_base),
    .rom_addr(rom_addr), .rom_data(rom_data), .act_addr(act_addr), .act_data(act_data),
    .busy(busy), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready));

  neuron_mac_seq #(.N(8), .Q(7), .NUM_IN(4), .ACC_W(24), .RELU(1)) dut_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .w_base(w_base),
    .rom_addr(rom_addr_r), .rom_data(rom_data_r), .act_addr(act_addr_r), .act_data(act_data_r),
    .busy(busy_r), .out_data(out_data_r), .out_valid(out_valid_r), .out_ready(out_ready));

  neuron_mac_seq #(.N(8), .Q(7), .NUM_IN(1), .ACC_W(24), .RELU(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .w_base(w_base1),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .act_addr(act_addr1), .act_data(act_data1),
    .busy(busy1), .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1));

  // ROM / activation buffer model: registers on the falling edge.
  always @(negedge clk) begin
    rom_data   <= wmem[rom_addr];
    act_data   <= amem[act_addr[1:0]];
    rom_data_r <= wmem[rom_addr_r];
    act_data_r <= amem[act_addr_r[1:0]];
    rom_data1  <= wmem[rom_addr1];
    act_data1  <= amem[act_addr1[1:0]];
  end

  typedef struct {
    logic [7:0]  base;
    logic [31:0] w;      // byte i = weight of term i
    logic [31:0] a;      // byte i = activation of term i
    logic [7:0]  exp;
    logic [7:0]  exp_relu;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic load_vec(input vec_t v);
    logic [7:0] idx;
    for (int i = 0; i < 4; i++) begin
      idx = v.base + 8'(i);
      wmem[idx] = v.w[8*i +: 8];
      amem[i]   = v.a[8*i +: 8];
    end
  endtask

  // Counts edges after the start edge until out_valid; 20 means timeout.
  task automatic wait_valid(input bit single, output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if ((single ? out_valid1 : out_valid) === 1'b1) break;
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int lat;
    load_vec(v);
    start = 1'b1; w_base = v.base;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
    wait_valid(1'b0, lat);
    check($sformatf("v%0d_latency", k), 32'(lat), 32'd5);
    check($sformatf("v%0d_data", k), 32'(out_data), 32'(v.exp));
    check($sformatf("v%0d_relu", k), 32'(out_data_r), 32'(v.exp_relu));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("v%0d_done", k), {30'd0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{8'h10, 32'h20202020, 32'h40404040, 8'h40, 8'h40};
    vecs[1]  = '{8'h20, 32'h40404040, 32'h40404040, 8'h7F, 8'h7F};
    vecs[2]  = '{8'h30, 32'hC0C0C0C0, 32'h40404040, 8'h80, 8'h00};
    vecs[3]  = '{8'h40, 32'h000000FF, 32'h00000001, 8'hFF, 8'h00};
    vecs[4]  = '{8'h50, 32'h00000001, 32'h00000001, 8'h00, 8'h00};
    vecs[5]  = '{8'h60, 32'hF010807F, 32'h10207F7F, 8'h01, 8'h01};
    vecs[6]  = '{8'h70, 32'h80808080, 32'h7F7F7F7F, 8'h80, 8'h00};
    vecs[7]  = '{8'h80, 32'h80808080, 32'h80808080, 8'h7F, 8'h7F};
    vecs[8]  = '{8'h90, 32'h00000003, 32'h000000FB, 8'hFF, 8'h00};
    vecs[9]  = '{8'hFE, 32'h04030201, 32'h40404040, 8'h05, 8'h05};
    vecs[10] = '{8'hA0, 32'h7F000000, 32'h40000000, 8'h3F, 8'h3F};

    for (int i = 0; i < 256; i++) wmem[i] = 8'h00;
    for (int i = 0; i < 4; i++) amem[i] = 8'h00;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; w_base = 8'h00;
    start1 = 1'b0; out_ready1 = 1'b0; w_base1 = 8'h00;

    #3;
    check("reset_state", {rom_addr, act_addr, out_data, 6'd0, out_valid, busy}, 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

    // Address sequence across the 0xFF -> 0x00 wrap.
    load_vec(vecs[9]);
    start = 1'b1; w_base = 8'hFE;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_addr%0d", i), {16'd0, rom_addr, act_addr},
            {16'd0, 8'(8'hFE + 8'(i)), 8'(i)});
      @(posedge clk); #1;
    end
    check("wrap_hold", {16'd0, rom_addr, act_addr}, {16'd0, 8'h01, 8'h03});
    wait_valid(1'b0, lat);
    check("wrap_data", 32'(out_data), 32'h05);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a run.
    load_vec(vecs[1]);
    start = 1'b1; w_base = vecs[1].base;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {rom_addr, act_addr, out_data, 6'd0, out_valid, busy}, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        check("no_stale_valid", {30'd0, out_valid, busy}, 32'd0);
        break;
      end
    end
    run_vec(vecs[2], 20);

    // Backpressure with ignored starts during RUN and OUT.
    load_vec(vecs[0]);
    start = 1'b1; w_base = vecs[0].base;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; w_base = 8'h70;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(1'b0, lat);
    check("bp_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("bp_hold%0d", i), {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h40});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {30'd0, out_valid, busy}, 32'd0);
    run_vec(vecs[5], 21);

    // NUM_IN=1: RUN is skipped, result after two edges.
    wmem[8'hC8] = 8'h40;
    amem[0]     = 8'h60;
    start1 = 1'b1; w_base1 = 8'hC8;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("n1_addr", {16'd0, rom_addr1, act_addr1}, {16'd0, 8'hC8, 8'h00});
    wait_valid(1'b1, lat);
    check("n1_latency", 32'(lat), 32'd2);
    check("n1_data", 32'(out_data1), 32'h30);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("n1_done", {30'd0, out_valid1, busy1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
